// File: rtl/stack_ctrl_pkg.sv
// Shared opcode, ALU-select, state and strobe definitions for the stack machine controller.
package stack_ctrl_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSHM = 3'b100;
    localparam logic [2:0] OP_POPM = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_RD, PUSH_MEM, POP_A, LOAD_A, POP_B, LOAD_B,
        ALU_NOT_S, ALU_OP, PUSH_RES, MEM_WR, JUMP, BRANCH, FAULT
    } state_t;

    typedef struct packed {
        logic IorD;
        logic srcA;
        logic srcB;
        logic lda;
        logic ldb;
        logic PCsrc;
        logic PCwrite;
        logic memRead;
        logic IRwrite;
        logic tos;
        logic pop;
        logic push;
        logic MtoS;
        logic PCwriteCond;
        logic memWrite;
    } strobes_t;

endpackage

// File: rtl/stack_controller_if.sv
// Controller <-> datapath bundle: IR opcode and memory handshake in, datapath strobes out.
interface stack_controller_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [2:0]       opcode;
    logic             mem_ready;
    logic             IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead;
    logic             IRwrite, tos, pop, push, MtoS, PCwriteCond, memWrite;
    logic [1:0]       ALUop;
    logic [CNT_W-1:0] depth_cnt;
    logic             instr_done;
    logic             fault;

    modport master (
        input  opcode, mem_ready,
        output IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead,
               IRwrite, tos, pop, push, MtoS, PCwriteCond, memWrite,
               ALUop, depth_cnt, instr_done, fault
    );

    modport slave (
        output opcode, mem_ready,
        input  IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead,
               IRwrite, tos, pop, push, MtoS, PCwriteCond, memWrite,
               ALUop, depth_cnt, instr_done, fault
    );
endinterface

// File: rtl/stack_depth_counter.sv
// Up/down stack occupancy counter with full/empty flags.
// Latency: count updates on the edge after inc/dec; flags are combinational from the count.
// Backpressure: none; callers guarantee no overflow/underflow and never inc and dec together.
module stack_depth_counter #(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/stack_controller.sv
// Multi-cycle control FSM for a stack-machine datapath with occupancy tracking and fault trapping.
// Latency: 3..8+ cycles per instruction depending on opcode and memory wait cycles.
// Backpressure: stalls in FETCH, MEM_RD and MEM_WR until mem_ready; FAULT holds until rst.
module stack_controller
    import stack_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    stack_controller_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t           state, state_nxt, cur;
    strobes_t         st;
    logic [1:0]       alu_op;
    logic             done;
    logic             rdy;
    logic             legal;
    logic [CNT_W-1:0] cnt;
    logic             full, empty;

    stack_depth_counter #(.DEPTH(DEPTH)) u_depth (
        .clk   (clk),
        .rst   (rst),
        .inc   (st.push),
        .dec   (st.pop),
        .cnt   (cnt),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand/space requirement for the opcode held in IR.
    always_comb begin
        legal = 1'b0;
        case (bus.opcode)
            OP_PUSHM:        legal = !full;
            OP_POPM, OP_NOT: legal = !empty;
            OP_JMP, OP_JZ:   legal = 1'b1;
            default:         legal = (cnt > CNT_W'(1));
        endcase
    end

    // While rst is high the outputs look like an idle FETCH with no memory response.
    always_comb begin
        st        = '0;
        alu_op    = ALU_ADD;
        done      = 1'b0;
        cur       = rst ? FETCH : state;
        rdy       = bus.mem_ready & ~rst;
        state_nxt = cur;
        case (cur)
            FETCH: begin
                st.srcA    = 1'b1;
                st.srcB    = 1'b1;
                st.memRead = 1'b1;
                if (rdy) begin
                    st.PCwrite = 1'b1;
                    st.IRwrite = 1'b1;
                    state_nxt  = DECODE;
                end
            end
            DECODE: begin
                st.tos = 1'b1;
                if (!legal) begin
                    state_nxt = FAULT;
                end else begin
                    case (bus.opcode)
                        OP_PUSHM: state_nxt = MEM_RD;
                        OP_JMP:   state_nxt = JUMP;
                        OP_JZ:    state_nxt = BRANCH;
                        default:  state_nxt = POP_A;
                    endcase
                end
            end
            MEM_RD: begin
                st.IorD    = 1'b1;
                st.memRead = 1'b1;
                if (rdy) state_nxt = PUSH_MEM;
            end
            PUSH_MEM: begin
                st.MtoS   = 1'b1;
                st.push   = 1'b1;
                done      = 1'b1;
                state_nxt = FETCH;
            end
            POP_A: begin
                st.pop    = 1'b1;
                state_nxt = LOAD_A;
            end
            LOAD_A: begin
                st.lda = 1'b1;
                case (bus.opcode)
                    OP_POPM: state_nxt = MEM_WR;
                    OP_NOT:  state_nxt = ALU_NOT_S;
                    default: state_nxt = POP_B;
                endcase
            end
            MEM_WR: begin
                st.IorD     = 1'b1;
                st.memWrite = 1'b1;
                if (rdy) begin
                    done      = 1'b1;
                    state_nxt = FETCH;
                end
            end
            POP_B: begin
                st.pop    = 1'b1;
                state_nxt = LOAD_B;
            end
            LOAD_B: begin
                st.ldb    = 1'b1;
                state_nxt = ALU_OP;
            end
            ALU_OP: begin
                alu_op    = bus.opcode[1:0];
                state_nxt = PUSH_RES;
            end
            ALU_NOT_S: begin
                alu_op    = ALU_NOT;
                state_nxt = PUSH_RES;
            end
            PUSH_RES: begin
                st.push   = 1'b1;
                done      = 1'b1;
                state_nxt = FETCH;
            end
            JUMP: begin
                st.PCsrc   = 1'b1;
                st.PCwrite = 1'b1;
                done       = 1'b1;
                state_nxt  = FETCH;
            end
            BRANCH: begin
                st.PCsrc       = 1'b1;
                st.PCwriteCond = 1'b1;
                done           = 1'b1;
                state_nxt      = FETCH;
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign bus.IorD        = st.IorD;
    assign bus.srcA        = st.srcA;
    assign bus.srcB        = st.srcB;
    assign bus.lda         = st.lda;
    assign bus.ldb         = st.ldb;
    assign bus.PCsrc       = st.PCsrc;
    assign bus.PCwrite     = st.PCwrite;
    assign bus.memRead     = st.memRead;
    assign bus.IRwrite     = st.IRwrite;
    assign bus.tos         = st.tos;
    assign bus.pop         = st.pop;
    assign bus.push        = st.push;
    assign bus.MtoS        = st.MtoS;
    assign bus.PCwriteCond = st.PCwriteCond;
    assign bus.memWrite    = st.memWrite;
    assign bus.ALUop       = alu_op;
    assign bus.depth_cnt   = cnt;
    assign bus.instr_done  = done;
    assign bus.fault       = (cur == FAULT);

endmodule
